// File: rtl/alu_pkg.sv
// ==========================================================================
// alu_pkg : FSM state encoding and op/ALU-control constants.  Rev 1.0
// ==========================================================================
`default_nettype none

package alu_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;
  localparam logic [2:0] CTRL_OR  = 3'b010;
  localparam logic [2:0] CTRL_AND = 3'b011;

  function automatic logic [2:0] op_to_ctrl(input logic [1:0] op);
    logic [2:0] ctrl;
    case (op)
      OP_ADD:  ctrl = CTRL_ADD;
      OP_SUB:  ctrl = CTRL_SUB;
      OP_OR:   ctrl = CTRL_OR;
      default: ctrl = CTRL_AND;
    endcase
    return ctrl;
  endfunction

  function automatic logic is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ALU_16bit.sv
// ==========================================================================
// ALU_16bit : combinational 16-bit ADD/SUB/OR/AND slice with carry/borrow.  Rev 1.0
// ==========================================================================
`default_nettype none

module ALU_16bit
  import alu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] y,
  output logic        cout
);

  logic [16:0] sum;

  // For SUB, cin is a borrow-in and bit 16 of the 17-bit difference is the borrow-out.
  always_comb begin
    sum = 17'd0;
    case (ctrl)
      CTRL_ADD: sum = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      CTRL_SUB: sum = {1'b0, a} - {1'b0, b} - {16'd0, cin};
      CTRL_OR:  sum = {1'b0, a | b};
      CTRL_AND: sum = {1'b0, a & b};
      default:  sum = 17'd0;
    endcase
  end

  assign y    = sum[15:0];
  assign cout = sum[16];

endmodule

`default_nettype wire

// File: rtl/alu_wide_seq.sv
// ==========================================================================
// alu_wide_seq : 32-bit ALU sequenced as two passes through one 16-bit slice.  Rev 1.0
// ==========================================================================
`default_nettype none

module alu_wide_seq
  import alu_pkg::*;
#(
  parameter int OP_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  output logic            busy,
  output logic            done,
  output logic [31:0]     result,
  output logic            cout,
  output logic            zero
);

  logic [1:0]  state_q,  state_d;
  logic [31:0] a_q,      a_d;
  logic [31:0] b_q,      b_d;
  logic [1:0]  op_q,     op_d;
  logic        carry_q,  carry_d;
  logic [31:0] result_q, result_d;
  logic        cout_q,   cout_d;
  logic        zero_q,   zero_d;
  logic        done_q,   done_d;

  logic [2:0]  alu_ctrl;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cin;
  logic [15:0] alu_y;
  logic        alu_cout;

  // The single slice sees the low halves in LO and the high halves in HI.
  always_comb begin
    alu_ctrl = op_to_ctrl(op_q);
    alu_a    = (state_q == S_HI) ? a_q[31:16] : a_q[15:0];
    alu_b    = (state_q == S_HI) ? b_q[31:16] : b_q[15:0];
    alu_cin  = (state_q == S_HI) && is_arith(op_q) && carry_q;
  end

  ALU_16bit u_alu (
    .ctrl (alu_ctrl),
    .a    (alu_a),
    .b    (alu_b),
    .cin  (alu_cin),
    .y    (alu_y),
    .cout (alu_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op[1:0];
          state_d = S_LO;
        end
      end
      S_LO: begin
        result_d[15:0] = alu_y;
        carry_d        = alu_cout;
        state_d        = S_HI;
      end
      S_HI: begin
        result_d[31:16] = alu_y;
        cout_d          = alu_cout;
        zero_d          = ({alu_y, result_q[15:0]} == 32'd0);
        state_d         = S_FIN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // done is registered out of FIN, so it lands on the cycle after FIN.
    done_d = (state_q == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= 2'd0;
      carry_q  <= 1'b0;
      result_q <= 32'd0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_wide_seq.sv
// ==========================================================================
// tb_alu_wide_seq : randomized and directed bench for alu_wide_seq.  Rev 1.0
// ==========================================================================
`default_nettype none

module tb_alu_wide_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        zero;

  int errors = 0;
  int checks = 0;

  alu_wide_seq #(.OP_W(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {cout, zero, result} from plain 32-bit arithmetic.
  function automatic logic [33:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] t;
    case (o)
      2'b00:   t = {1'b0, x} + {1'b0, y};
      2'b01:   t = {(x < y), x - y};
      2'b10:   t = {1'b0, x | y};
      default: t = {1'b0, x & y};
    endcase
    return {t[32], (t[31:0] == 32'd0), t[31:0]};
  endfunction

  // Launch one op, then watch 8 cycles while scrambling operands.
  task automatic do_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                       input int rst_k, input logic [2:0] pulse_mask,
                       output int ndone, output int lat,
                       output logic [33:0] got_done, output logic [33:0] got_end,
                       output logic [2:0] busy_vec, output logic [34:0] snap);
    op = op_i; a = a_i; b = b_i; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; lat = -1; got_done = '0; busy_vec = '0; snap = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < 3) busy_vec[k] = busy;
      if (done === 1'b1) begin
        ndone++;
        lat = k;
        got_done = {cout, zero, result};
      end
      if (k == rst_k + 1) snap = {busy, done, cout, zero, result};
      start = (k < 3) ? pulse_mask[k] : 1'b0;
      rst   = (k == rst_k);
      op    = 2'($urandom_range(3));
      a     = $urandom;
      b     = $urandom;
      @(posedge clk); #1;
    end
    got_end = {cout, zero, result};
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; op = 2'b00; a = $urandom; b = $urandom;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
    checks++; if (cout !== 1'b0)    begin errors++; $display("FAIL reset_cout got=%b want=0", cout); end
    checks++; if (zero !== 1'b0)    begin errors++; $display("FAIL reset_zero got=%b want=0", zero); end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [1:0]  vo [6];
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [33:0] ve [6];
    int nd, lt;
    logic [33:0] gd, ge;
    logic [2:0]  bv;
    logic [34:0] sn;
    vo[0] = 2'b00; va[0] = 32'h0000FFFF; vb[0] = 32'h00000001; ve[0] = {1'b0, 1'b0, 32'h00010000};
    vo[1] = 2'b00; va[1] = 32'hFFFFFFFF; vb[1] = 32'h00000001; ve[1] = {1'b1, 1'b1, 32'h00000000};
    vo[2] = 2'b01; va[2] = 32'h00010000; vb[2] = 32'h00000001; ve[2] = {1'b0, 1'b0, 32'h0000FFFF};
    vo[3] = 2'b01; va[3] = 32'h00000000; vb[3] = 32'h00000001; ve[3] = {1'b1, 1'b0, 32'hFFFFFFFF};
    vo[4] = 2'b10; va[4] = 32'hF0F00000; vb[4] = 32'h0000F0F0; ve[4] = {1'b0, 1'b0, 32'hF0F0F0F0};
    vo[5] = 2'b11; va[5] = 32'hFFFF0000; vb[5] = 32'h0000FFFF; ve[5] = {1'b0, 1'b1, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      do_op(vo[i], va[i], vb[i], -1, 3'b000, nd, lt, gd, ge, bv, sn);
      checks++; if (nd !== 1)      begin errors++; $display("FAIL dir%0d_done_count got=%0d want=1", i, nd); end
      checks++; if (lt !== 3)      begin errors++; $display("FAIL dir%0d_latency got=%0d want=3", i, lt); end
      checks++; if (gd !== ve[i])  begin errors++; $display("FAIL dir%0d_result got=%h want=%h", i, gd, ve[i]); end
      checks++; if (ge !== ve[i])  begin errors++; $display("FAIL dir%0d_hold got=%h want=%h", i, ge, ve[i]); end
      checks++; if (bv !== 3'b111) begin errors++; $display("FAIL dir%0d_busy got=%b want=111", i, bv); end
    end
  endtask

  task automatic test_random;
    int nd, lt;
    logic [33:0] gd, ge, ex;
    logic [2:0]  bv;
    logic [34:0] sn;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(3));
      ra = (i % 5 == 0) ? 32'hFFFFFFFF : $urandom;
      rb = (i % 7 == 0) ? ra : $urandom;
      if (i % 6 == 3) rb = 32'd0;
      ex = model(ro, ra, rb);
      do_op(ro, ra, rb, -1, 3'b000, nd, lt, gd, ge, bv, sn);
      checks++; if (nd !== 1 || lt !== 3) begin errors++; $display("FAIL rnd%0d_timing got=%0d/%0d want=1/3", i, nd, lt); end
      checks++; if (gd !== ex) begin errors++; $display("FAIL rnd%0d_op%0d a=%h b=%h got=%h want=%h", i, ro, ra, rb, gd, ex); end
    end
  endtask

  task automatic test_ignore_start;
    int nd, lt;
    logic [33:0] gd, ge, ex;
    logic [2:0]  bv;
    logic [34:0] sn;
    ex = model(2'b00, 32'h12348000, 32'h0000C000);
    do_op(2'b00, 32'h12348000, 32'h0000C000, -1, 3'b011, nd, lt, gd, ge, bv, sn);
    checks++; if (nd !== 1)  begin errors++; $display("FAIL ign_lohi_done_count got=%0d want=1", nd); end
    checks++; if (gd !== ex) begin errors++; $display("FAIL ign_lohi_result got=%h want=%h", gd, ex); end
    checks++; if (ge !== ex) begin errors++; $display("FAIL ign_lohi_hold got=%h want=%h", ge, ex); end
    ex = model(2'b01, 32'h00000005, 32'h00000009);
    do_op(2'b01, 32'h00000005, 32'h00000009, -1, 3'b100, nd, lt, gd, ge, bv, sn);
    checks++; if (nd !== 1 || lt !== 3) begin errors++; $display("FAIL ign_fin_timing got=%0d/%0d want=1/3", nd, lt); end
    checks++; if (ge !== ex) begin errors++; $display("FAIL ign_fin_result got=%h want=%h", ge, ex); end
  endtask

  task automatic test_rst_mid;
    int nd, lt;
    logic [33:0] gd, ge, ex;
    logic [2:0]  bv;
    logic [34:0] sn;
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 3'b000, nd, lt, gd, ge, bv, sn);
    checks++; if (nd !== 0)     begin errors++; $display("FAIL rst_hi_done_count got=%0d want=0", nd); end
    checks++; if (sn !== 35'd0) begin errors++; $display("FAIL rst_hi_outputs got=%h want=0", sn); end
    checks++; if (ge !== 34'd0) begin errors++; $display("FAIL rst_hi_idle got=%h want=0", ge); end
    do_op(2'b10, 32'hA5A5A5A5, 32'h5A5A5A5A, 2, 3'b000, nd, lt, gd, ge, bv, sn);
    checks++; if (nd !== 0)     begin errors++; $display("FAIL rst_fin_done_count got=%0d want=0", nd); end
    ex = model(2'b01, 32'h00000003, 32'h00000001);
    do_op(2'b01, 32'h00000003, 32'h00000001, -1, 3'b000, nd, lt, gd, ge, bv, sn);
    checks++; if (nd !== 1 || lt !== 3) begin errors++; $display("FAIL rst_recover_timing got=%0d/%0d want=1/3", nd, lt); end
    checks++; if (gd !== ex) begin errors++; $display("FAIL rst_recover_result got=%h want=%h", gd, ex); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  bo [4];
    logic [31:0] ba [4];
    logic [31:0] bb [4];
    int nd;
    logic [33:0] ex;
    for (int j = 0; j < 4; j++) begin
      bo[j] = 2'(j);
      ba[j] = $urandom;
      bb[j] = $urandom;
    end
    nd = 0;
    op = bo[0]; a = ba[0]; b = bb[0]; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) begin
        nd++;
        ex = model(bo[c / 4], ba[c / 4], bb[c / 4]);
        checks++;
        if (c % 4 != 3 || {cout, zero, result} !== ex) begin
          errors++;
          $display("FAIL b2b_op%0d cycle=%0d got=%h want=%h", c / 4, c, {cout, zero, result}, ex);
        end
      end
      if (c % 4 == 3 && c / 4 + 1 < 4) begin
        op = bo[c / 4 + 1]; a = ba[c / 4 + 1]; b = bb[c / 4 + 1]; start = 1'b1;
      end else begin
        if (c % 4 == 3) start = 1'b0;
        op = 2'($urandom_range(3)); a = $urandom; b = $urandom;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (nd !== 4) begin errors++; $display("FAIL b2b_done_count got=%0d want=4", nd); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_rst_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_wide_seq.md
ALU_WIDE_SEQ -- requirements
Module: alu_wide_seq

Interface
REQ-001 SHALL have parameter OP_W, default 2, width of the operation code.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin one 32-bit operation.
REQ-005 SHALL have port op, input, OP_W, operation: 00 ADD, 01 SUB, 10 OR, 11 AND.
REQ-006 SHALL have port a, input, 32, first operand.
REQ-007 SHALL have port b, input, 32, second operand.
REQ-008 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, 32, registered 32-bit result.
REQ-011 SHALL have port cout, output, 1, registered carry (ADD) or borrow (SUB) out of bit 31; 0 for OR/AND.
REQ-012 SHALL have port zero, output, 1, registered flag, high when result equals 0.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, LO, HI, FIN.
REQ-014 IDLE: start=1 SHALL latch a, b, op into internal registers and go to LO; start=0 stays in IDLE.
REQ-015 start SHALL be sampled only in IDLE; start in LO, HI or FIN SHALL be ignored, with no queuing.
REQ-016 LO: the 16-bit ALU SHALL compute on a[15:0], b[15:0] with Cin=0; the low result and Cout SHALL be registered; next state is HI.
REQ-017 HI: the 16-bit ALU SHALL compute on a[31:16], b[31:16] with Cin equal to the registered LO Cout for ADD/SUB, and Cin=0 for OR/AND; next state is FIN.
REQ-018 At the HI->FIN edge, result[31:16], cout and zero SHALL be registered; zero SHALL be computed over all 32 result bits.
REQ-019 FIN: done SHALL be 1 for exactly one cycle; next state is IDLE.
REQ-020 Latency: with start sampled at edge N, done SHALL be high during the cycle following edge N+3.
REQ-021 Throughput: one operation per 4 cycles; back-to-back start held high SHALL be accepted on every IDLE cycle.
REQ-022 result, cout and zero SHALL hold their values from FIN until the next operation writes them; they SHALL NOT change while in IDLE.
REQ-023 ALU control mapping: ADD=000, SUB=001, OR=010, AND=011; control codes 100-111 SHALL never be driven.
REQ-024 SUB SHALL compute a-b modulo 2^32; cout=1 SHALL indicate a borrow (unsigned a<b).
REQ-025 Operand inputs SHALL be don't-care after the start cycle; changes to a, b or op mid-operation SHALL NOT affect the result.

Reset
REQ-026 rst=1 at any clock edge SHALL force IDLE and busy=0, done=0, result=0, cout=0, zero=0, and clear all internal operand and carry registers.
REQ-027 rst asserted mid-operation SHALL abort the operation with no done pulse; rst has priority over start.

Structure
REQ-028 The state encoding and op-code constants SHALL live in a shared package, alu_pkg.
REQ-029 The block SHALL instantiate exactly one ALU_16bit as its only sub-module; the datapath SHALL NOT be duplicated.

Verification
REQ-030 ADD a=0x0000FFFF, b=0x00000001 -> done 4 cycles after start; result=0x00010000, cout=0, zero=0.
REQ-031 ADD a=0xFFFFFFFF, b=0x00000001 -> result=0x00000000, cout=1, zero=1.
REQ-032 SUB a=0x00010000, b=0x00000001 -> result=0x0000FFFF, cout=0; SUB a=0, b=1 -> result=0xFFFFFFFF, cout=1.
REQ-033 OR a=0xF0F00000, b=0x0000F0F0 -> result=0xF0F0F0F0; AND a=0xFFFF0000, b=0x0000FFFF -> result=0, zero=1, cout=0.
REQ-034 start pulsed again in LO and in HI with different operands -> ignored; first result unchanged and exactly one done pulse.
REQ-035 rst asserted in HI -> next cycle state IDLE, all outputs 0, no done; a following start completes normally.
